// File: rtl/pcie_usp_cq_reg_completer.sv
// Register completer for the PCIe UltraScale+ CQ/CC AXI-Stream pair: a 16 x 32-bit register
// file written by single-dword memory writes and returned by two-beat memory-read completions.
module pcie_usp_cq_reg_completer #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 32,
  parameter int unsigned CQ_USER_WIDTH = 88,
  parameter int unsigned CC_USER_WIDTH = 33
) (
  input  logic                     user_clk,
  input  logic                     user_reset,
  input  logic [DATA_WIDTH-1:0]    s_axis_cq_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
  input  logic                     s_axis_cq_tlast,
  input  logic [CQ_USER_WIDTH-1:0] s_axis_cq_tuser,
  input  logic                     s_axis_cq_tvalid,
  output logic                     s_axis_cq_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_cc_tkeep,
  output logic                     m_axis_cc_tlast,
  output logic [CC_USER_WIDTH-1:0] m_axis_cc_tuser,
  output logic                     m_axis_cc_tvalid,
  input  logic [3:0]               m_axis_cc_tready,
  output logic [1:0]               pcie_cq_np_req,
  output logic [31:0]              ctrl_reg
);

  localparam int unsigned NUM_REGS = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_WR_DATA, S_DROP, S_CPL0, S_CPL1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [4:0]  addr_q;
  logic [3:0]  first_be_q;
  logic [15:0] req_id_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q;
  logic [2:0]  attr_q;
  logic        ur_q;
  logic [31:0] rd_data_q;

  logic [10:0] hdr_dw_c;
  logic [3:0]  hdr_type_c;
  logic        cq_ready_c;
  logic        cc_valid_c;
  logic        cq_hs_c;
  logic        cc_hs_c;
  logic [DATA_WIDTH-1:0] cc_beat0_c;
  logic [DATA_WIDTH-1:0] cc_beat1_c;
  logic        unused_inputs_c;

  assign hdr_dw_c   = s_axis_cq_tdata[10:0];
  assign hdr_type_c = s_axis_cq_tdata[14:11];
  assign cq_hs_c    = s_axis_cq_tvalid & cq_ready_c;
  assign cc_hs_c    = cc_valid_c & m_axis_cc_tready[0];
  assign ctrl_reg   = regs_q[0];
  assign unused_inputs_c = ^{s_axis_cq_tdata, s_axis_cq_tkeep, s_axis_cq_tuser, m_axis_cc_tready};

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cq_hs_c) state_d = S_HDR1;
      S_HDR1: begin
        if (cq_hs_c) begin
          if (hdr_type_c == 4'b0001 && hdr_dw_c == 11'd1) state_d = S_WR_DATA;
          else if (hdr_type_c == 4'b0000) state_d = s_axis_cq_tlast ? S_CPL0 : S_DROP;
          else                            state_d = s_axis_cq_tlast ? S_IDLE : S_DROP;
        end
      end
      S_WR_DATA: if (cq_hs_c) state_d = S_IDLE;
      S_DROP:    if (cq_hs_c && s_axis_cq_tlast) state_d = S_IDLE;
      S_CPL0:    if (cc_hs_c) state_d = S_CPL1;
      S_CPL1:    if (cc_hs_c) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Completion descriptor and payload, built from the captured request fields.
  always_comb begin
    cc_beat0_c         = '0;
    cc_beat0_c[6:0]    = {addr_q, 2'b00};
    cc_beat0_c[28:16]  = 13'd4;
    cc_beat0_c[42:32]  = ur_q ? 11'd0 : 11'd1;
    cc_beat0_c[45:43]  = ur_q ? 3'b001 : 3'b000;
    cc_beat0_c[63:48]  = req_id_q;
    cc_beat1_c         = '0;
    cc_beat1_c[7:0]    = tag_q;
    cc_beat1_c[27:25]  = tc_q;
    cc_beat1_c[30:28]  = attr_q;
    cc_beat1_c[63:32]  = rd_data_q;
  end

  // Reset forces every handshake output low, not just the state.
  always_comb begin
    cq_ready_c       = 1'b0;
    cc_valid_c       = 1'b0;
    m_axis_cc_tdata  = '0;
    m_axis_cc_tlast  = 1'b0;
    m_axis_cc_tuser  = '0;
    pcie_cq_np_req   = 2'b00;
    if (!user_reset) begin
      pcie_cq_np_req = 2'b01;
      case (state_q)
        S_IDLE, S_HDR1, S_WR_DATA, S_DROP: cq_ready_c = 1'b1;
        S_CPL0: begin
          cc_valid_c      = 1'b1;
          m_axis_cc_tdata = cc_beat0_c;
        end
        S_CPL1: begin
          cc_valid_c      = 1'b1;
          m_axis_cc_tdata = cc_beat1_c;
          m_axis_cc_tlast = 1'b1;
        end
        default: cq_ready_c = 1'b0;
      endcase
    end
    s_axis_cq_tready = cq_ready_c;
    m_axis_cc_tvalid = cc_valid_c;
    m_axis_cc_tkeep  = cc_valid_c ? {KEEP_WIDTH{1'b1}} : {KEEP_WIDTH{1'b0}};
  end

  // Request capture and byte-enabled register writes.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      addr_q     <= '0;
      first_be_q <= '0;
      req_id_q   <= '0;
      tag_q      <= '0;
      tc_q       <= '0;
      attr_q     <= '0;
      ur_q       <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (state_q == S_IDLE && cq_hs_c) begin
        addr_q     <= s_axis_cq_tdata[6:2];
        first_be_q <= s_axis_cq_tuser[3:0];
      end
      if (state_q == S_HDR1 && cq_hs_c) begin
        req_id_q  <= s_axis_cq_tdata[31:16];
        tag_q     <= s_axis_cq_tdata[39:32];
        tc_q      <= s_axis_cq_tdata[59:57];
        attr_q    <= s_axis_cq_tdata[62:60];
        ur_q      <= (hdr_dw_c != 11'd1);
        rd_data_q <= (hdr_dw_c == 11'd1) ? regs_q[addr_q[3:0]] : 32'd0;
      end
      if (state_q == S_WR_DATA && cq_hs_c) begin
        for (int b = 0; b < 4; b++) begin
          if (first_be_q[b]) regs_q[addr_q[3:0]][8*b +: 8] <= s_axis_cq_tdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_usp_cq_reg_completer.sv
// Bench for pcie_usp_cq_reg_completer: directed vector table, corner-case sequences and
// randomized traffic checked against an array model of the register file.
module tb_pcie_usp_cq_reg_completer;

  logic        user_clk = 1'b0;
  logic        user_reset;
  logic [63:0] s_axis_cq_tdata;
  logic [1:0]  s_axis_cq_tkeep;
  logic        s_axis_cq_tlast;
  logic [87:0] s_axis_cq_tuser;
  logic        s_axis_cq_tvalid;
  logic        s_axis_cq_tready;
  logic [63:0] m_axis_cc_tdata;
  logic [1:0]  m_axis_cc_tkeep;
  logic        m_axis_cc_tlast;
  logic [32:0] m_axis_cc_tuser;
  logic        m_axis_cc_tvalid;
  logic [3:0]  m_axis_cc_tready;
  logic [1:0]  pcie_cq_np_req;
  logic [31:0] ctrl_reg;

  pcie_usp_cq_reg_completer dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_axis_cq_tdata(s_axis_cq_tdata), .s_axis_cq_tkeep(s_axis_cq_tkeep),
    .s_axis_cq_tlast(s_axis_cq_tlast), .s_axis_cq_tuser(s_axis_cq_tuser),
    .s_axis_cq_tvalid(s_axis_cq_tvalid), .s_axis_cq_tready(s_axis_cq_tready),
    .m_axis_cc_tdata(m_axis_cc_tdata), .m_axis_cc_tkeep(m_axis_cc_tkeep),
    .m_axis_cc_tlast(m_axis_cc_tlast), .m_axis_cc_tuser(m_axis_cc_tuser),
    .m_axis_cc_tvalid(m_axis_cc_tvalid), .m_axis_cc_tready(m_axis_cc_tready),
    .pcie_cq_np_req(pcie_cq_np_req), .ctrl_reg(ctrl_reg)
  );

  always #5 user_clk = ~user_clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] model [16];

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [10:0] dw;
    logic [7:0]  tag;
    logic [31:0] exp_data;
    logic [2:0]  exp_status;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] hdr1(input logic [10:0] dw, input logic [3:0] typ,
                                       input logic [15:0] rid, input logic [7:0] tag,
                                       input logic [2:0] tc, input logic [2:0] attr);
    logic [63:0] d;
    d = '0;
    d[10:0] = dw; d[14:11] = typ; d[31:16] = rid; d[39:32] = tag;
    d[59:57] = tc; d[62:60] = attr;
    return d;
  endfunction

  task automatic cq_beat(input logic [63:0] d, input logic [3:0] be, input logic last);
    int n = 0;
    @(negedge user_clk);
    s_axis_cq_tdata  = d;
    s_axis_cq_tuser  = '0;
    s_axis_cq_tuser[3:0] = be;
    s_axis_cq_tkeep  = 2'b11;
    s_axis_cq_tlast  = last;
    s_axis_cq_tvalid = 1'b1;
    while (!s_axis_cq_tready && n < 50) begin
      @(negedge user_clk);
      n++;
    end
    if (n >= 50) check("cq_tready_timeout", 64'(s_axis_cq_tready), 64'd1);
    @(posedge user_clk);
    #1;
    s_axis_cq_tvalid = 1'b0;
    s_axis_cq_tlast  = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] be,
                          input logic [10:0] dw, input logic [3:0] typ);
    int nb;
    nb = (dw == 0) ? 1 : int'(dw);
    cq_beat(64'(addr), be, 1'b0);
    cq_beat(hdr1(dw, typ, 16'h0101, 8'h00, 3'd0, 3'd0), 4'h0, 1'b0);
    for (int i = 0; i < nb; i++) cq_beat({32'h0, data}, 4'h0, (i == nb - 1));
    if (typ == 4'b0001 && dw == 11'd1)
      for (int b = 0; b < 4; b++) if (be[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic do_read(input logic [6:0] addr, input logic [10:0] dw, input logic [7:0] tag,
                         input logic [15:0] rid, input logic [2:0] tc, input logic [2:0] attr,
                         input int stall, output logic [63:0] b0, output logic [63:0] b1,
                         output logic l0, output logic l1);
    if (stall > 0) m_axis_cc_tready = 4'h0;
    cq_beat(64'(addr), 4'hF, 1'b0);
    cq_beat(hdr1(dw, 4'b0000, rid, tag, tc, attr), 4'h0, 1'b1);
    @(negedge user_clk);
    check("cc_latency_valid", 64'(m_axis_cc_tvalid), 64'd1);
    check("cc_beat0_keep_user", {29'd0, m_axis_cc_tuser, m_axis_cc_tkeep}, 64'd3);
    b0 = m_axis_cc_tdata;
    l0 = m_axis_cc_tlast;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 64'(m_axis_cc_tvalid), 64'd1);
      check("stall_data", m_axis_cc_tdata, b0);
      check("stall_cq_ready", 64'(s_axis_cq_tready), 64'd0);
      @(negedge user_clk);
    end
    m_axis_cc_tready = 4'hF;
    @(negedge user_clk);
    b1 = m_axis_cc_tdata;
    l1 = m_axis_cc_tlast;
    check("cpl1_valid", 64'(m_axis_cc_tvalid), 64'd1);
    check("cpl1_cq_ready", 64'(s_axis_cq_tready), 64'd0);
    @(posedge user_clk);
    #1;
    check("cc_done", 64'(m_axis_cc_tvalid), 64'd0);
  endtask

  task automatic check_cpl(input logic [63:0] b0, input logic [63:0] b1, input logic l0,
                           input logic l1, input logic [6:0] addr, input logic [7:0] tag,
                           input logic [15:0] rid, input logic [2:0] tc, input logic [2:0] attr,
                           input logic [31:0] exp_data, input logic [2:0] exp_status);
    check("cc_lower_addr", 64'(b0[6:0]), 64'(addr & 7'h7C));
    check("cc_byte_count", 64'(b0[28:16]), 64'd4);
    check("cc_dword_count", 64'(b0[42:32]), (exp_status == 3'b000) ? 64'd1 : 64'd0);
    check("cc_status", 64'(b0[45:43]), 64'(exp_status));
    check("cc_requester_id", 64'(b0[63:48]), 64'(rid));
    check("cc_tag_tc_attr", {b1[30:24], b1[7:0]}, {attr, tc, 1'b0, tag});
    check("cc_read_data", 64'(b1[63:32]), 64'(exp_data));
    check("cc_tlast", {l0, l1}, 64'b01);
  endtask

  logic [63:0] b0, b1;
  logic        l0, l1;

  initial begin
    vt[0] = '{1'b1, 7'h04, 32'hDEADBEEF, 4'hF, 11'd1, 8'h00, 32'h0,        3'd0, 32'h0};
    vt[1] = '{1'b0, 7'h04, 32'h0,        4'hF, 11'd1, 8'h12, 32'hDEADBEEF, 3'd0, 32'h0};
    vt[2] = '{1'b1, 7'h00, 32'h11223344, 4'h5, 11'd1, 8'h00, 32'h0,        3'd0, 32'h00220044};
    vt[3] = '{1'b0, 7'h00, 32'h0,        4'hF, 11'd1, 8'h01, 32'h00220044, 3'd0, 32'h00220044};
    vt[4] = '{1'b1, 7'h3C, 32'hAABBCCDD, 4'h6, 11'd1, 8'h00, 32'h0,        3'd0, 32'h00220044};
    vt[5] = '{1'b0, 7'h3C, 32'h0,        4'hF, 11'd1, 8'h7F, 32'h00BBCC00, 3'd0, 32'h00220044};
    vt[6] = '{1'b1, 7'h08, 32'h55667788, 4'hF, 11'd2, 8'h00, 32'h0,        3'd0, 32'h00220044};
    vt[7] = '{1'b0, 7'h08, 32'h0,        4'hF, 11'd1, 8'h33, 32'h0,        3'd0, 32'h00220044};
    vt[8] = '{1'b0, 7'h04, 32'h0,        4'hF, 11'd2, 8'h44, 32'h0,        3'd1, 32'h00220044};
    vt[9] = '{1'b0, 7'h44, 32'h0,        4'hF, 11'd1, 8'hA5, 32'hDEADBEEF, 3'd0, 32'h00220044};

    for (int i = 0; i < 16; i++) model[i] = '0;
    user_reset = 1'b1;
    s_axis_cq_tdata = '0; s_axis_cq_tkeep = '0; s_axis_cq_tlast = 1'b0;
    s_axis_cq_tuser = '0; s_axis_cq_tvalid = 1'b0; m_axis_cc_tready = 4'hF;
    repeat (3) @(negedge user_clk);
    check("reset_outputs", {m_axis_cc_tdata[31:0], ctrl_reg[27:0], s_axis_cq_tready,
                            m_axis_cc_tvalid, m_axis_cc_tlast, |pcie_cq_np_req}, 64'd0);
    check("reset_tdata_hi", m_axis_cc_tdata, 64'd0);
    user_reset = 1'b0;
    @(negedge user_clk);
    check("idle_ready_np", {s_axis_cq_tready, pcie_cq_np_req, m_axis_cc_tvalid}, 64'b1010);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) begin
        do_write(vt[i].addr, vt[i].data, vt[i].be, vt[i].dw, 4'b0001);
      end else begin
        do_read(vt[i].addr, vt[i].dw, vt[i].tag, 16'hABCD, 3'd5, 3'd3, 0, b0, b1, l0, l1);
        check_cpl(b0, b1, l0, l1, vt[i].addr, vt[i].tag, 16'hABCD, 3'd5, 3'd3,
                  vt[i].exp_data, vt[i].exp_status);
      end
      check("ctrl_reg", 64'(ctrl_reg), 64'(vt[i].exp_ctrl));
    end

    // Backpressured completion.
    do_read(7'h04, 11'd1, 8'h21, 16'h1234, 3'd1, 3'd2, 5, b0, b1, l0, l1);
    check_cpl(b0, b1, l0, l1, 7'h04, 8'h21, 16'h1234, 3'd1, 3'd2, model[1], 3'd0);

    // I/O request is swallowed without a completion or register change.
    do_write(7'h00, 32'hFFFFFFFF, 4'hF, 11'd1, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      @(negedge user_clk);
      check("io_no_cc", 64'(m_axis_cc_tvalid), 64'd0);
    end
    check("io_ctrl_unchanged", 64'(ctrl_reg), 64'h00220044);
    do_read(7'h00, 11'd1, 8'h02, 16'h0001, 3'd0, 3'd0, 0, b0, b1, l0, l1);
    check_cpl(b0, b1, l0, l1, 7'h00, 8'h02, 16'h0001, 3'd0, 3'd0, 32'h00220044, 3'd0);

    // Randomized traffic against the array model.
    for (int n = 0; n < 40; n++) begin
      logic [6:0]  a;
      logic [10:0] dw;
      logic [7:0]  tg;
      logic [15:0] rid;
      logic [2:0]  tc, at;
      a = 7'($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 1) == 0) begin
        dw = ($urandom_range(0, 3) == 0) ? 11'd2 : 11'd1;
        do_write(a, $urandom, 4'($urandom), dw, 4'b0001);
        check("rand_ctrl_reg", 64'(ctrl_reg), 64'(model[0]));
      end else begin
        dw  = ($urandom_range(0, 4) == 0) ? 11'd2 : 11'd1;
        tg  = 8'($urandom); rid = 16'($urandom);
        tc  = 3'($urandom); at  = 3'($urandom);
        do_read(a, dw, tg, rid, tc, at, int'($urandom_range(0, 2)), b0, b1, l0, l1);
        check_cpl(b0, b1, l0, l1, a, tg, rid, tc, at,
                  (dw == 11'd1) ? model[a[5:2]] : 32'h0, (dw == 11'd1) ? 3'd0 : 3'd1);
      end
    end

    // Reset in the middle of a completion.
    cq_beat(64'(7'h04), 4'hF, 1'b0);
    cq_beat(hdr1(11'd1, 4'b0000, 16'h5555, 8'h66, 3'd0, 3'd0), 4'h0, 1'b1);
    @(negedge user_clk);
    check("mid_cpl0_valid", 64'(m_axis_cc_tvalid), 64'd1);
    user_reset = 1'b1;
    #1;
    check("mid_reset_outputs", {m_axis_cc_tdata[55:0], s_axis_cq_tready, m_axis_cc_tvalid,
                                m_axis_cc_tlast, pcie_cq_np_req, |ctrl_reg}, 64'd0);
    repeat (2) @(negedge user_clk);
    user_reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge user_clk);
      check("post_reset_no_cc", 64'(m_axis_cc_tvalid), 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(7'(i * 4), 11'd1, 8'(i), 16'h0, 3'd0, 3'd0, 0, b0, b1, l0, l1);
      check("post_reset_reg", 64'(b1[63:32]), 64'(model[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
